// File: rtl/pipelined_signed_adder_pkg.sv
// Shared types and constant helpers for the pipelined signed adder.
// Token control bits travel in tok_ctl_t; operand/sum vectors sit beside it.
package adder_pkg;

  localparam int MAXW = 64;

  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } tok_ctl_t;

  function automatic int stages(input int n, input int seg);
    return n / seg;
  endfunction

  function automatic logic [MAXW-1:0] sat_max(input int n);
    return (MAXW'(1) << (n - 1)) - MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] sat_min(input int n);
    return MAXW'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/pipelined_signed_adder_rca_segment.sv
// Combinational W-bit ripple-carry slice used by each adder stage.
module rca_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic c;

  always_comb begin
    s_o = '0;
    c   = ci_i;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/pipelined_signed_adder.sv
// Pipelined two's-complement adder: one SEG-bit ripple segment per stage,
// valid/ready streaming with full backpressure and optional saturation.
module pipelined_signed_adder
  import adder_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 4,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         V
);

  localparam int STAGES = stages(N, SEG);
  localparam int L      = STAGES - 1;
  localparam logic [N-1:0] SMAX = N'(sat_max(N));
  localparam logic [N-1:0] SMIN = N'(sat_min(N));

  if (N < 2 || N > MAXW || (N % SEG) != 0) begin : g_bad_param
    $error("pipelined_signed_adder: N must be 2..64 and a multiple of SEG");
  end

  tok_ctl_t     ctl_q   [STAGES];
  tok_ctl_t     ctl_d   [STAGES];
  tok_ctl_t     src_ctl [STAGES];
  logic [N-1:0] sum_q   [STAGES];
  logic [N-1:0] sum_d   [STAGES];
  logic [N-1:0] src_sum [STAGES];
  logic [N-1:0] a_q     [STAGES];
  logic [N-1:0] a_d     [STAGES];
  logic [N-1:0] src_a   [STAGES];
  logic [N-1:0] b_q     [STAGES];
  logic [N-1:0] b_d     [STAGES];
  logic [N-1:0] src_b   [STAGES];

  logic [STAGES-1:0][SEG-1:0] seg_a;
  logic [STAGES-1:0][SEG-1:0] seg_b;
  logic [STAGES-1:0][SEG-1:0] seg_s;
  logic [STAGES-1:0]          seg_ci;
  logic [STAGES-1:0]          seg_co;

  logic         adv;
  tok_ctl_t     last;
  logic [N-1:0] sum_raw;
  logic         ovf;

  assign adv      = !ctl_q[L].valid | out_ready;
  assign in_ready = adv;

  // Stage 0 reads the ports; stage k reads the token left by stage k-1.
  always_comb begin
    src_ctl[0] = '{valid: in_valid, carry: Cin,
                   a_msb: A[N-1], b_msb: B[N-1]};
    src_a[0]   = A;
    src_b[0]   = B;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_ctl[k] = ctl_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
  end

  always_comb begin
    seg_a  = '0;
    seg_b  = '0;
    seg_ci = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_a[k]  = src_a[k][SEG-1:0];
      seg_b[k]  = src_b[k][SEG-1:0];
      seg_ci[k] = src_ctl[k].carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    rca_segment #(.W(SEG)) u_rca (
      .a_i  (seg_a[k]),
      .b_i  (seg_b[k]),
      .ci_i (seg_ci[k]),
      .s_o  (seg_s[k]),
      .co_o (seg_co[k])
    );
  end

  // Remaining operand bits shift down; finished sum bits shift in from the top.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ctl_d[k]       = src_ctl[k];
      ctl_d[k].carry = seg_co[k];
      a_d[k]         = src_a[k] >> SEG;
      b_d[k]         = src_b[k] >> SEG;
      sum_d[k]       = (src_sum[k] >> SEG)
                     | (N'(seg_s[k]) << (N - SEG));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= ctl_d[k];
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign last    = ctl_q[L];
  assign sum_raw = sum_q[L];
  assign ovf     = (last.a_msb == last.b_msb)
                 & (sum_raw[N-1] != last.a_msb);

  assign out_valid = last.valid;
  assign Cout      = last.carry;
  assign V         = ovf;
  assign Sum       = (SAT && ovf) ? (last.a_msb ? SMIN : SMAX)
                                  : sum_raw;

endmodule

// File: tb/tb_pipelined_signed_adder.sv
// Scoreboard bench for pipelined_signed_adder across four configurations.
module tb_pipelined_signed_adder;

  typedef struct {
    int          u;
    logic [15:0] s;
    logic        c;
    logic        v;
    int          cyc;
    bit          lc;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] A, B;
  logic Cin;
  logic [3:0] iv, rdy, ov, ordy, co, vf;
  logic [3:0][15:0] sum;

  sb_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  n_out = 0;
  bit  lat_chk = 1'b1;
  logic [15:0] held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_signed_adder #(.N(16), .SEG(4), .SAT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
    .A(A), .B(B), .Cin(Cin), .out_valid(ov[0]), .out_ready(ordy[0]),
    .Sum(sum[0]), .Cout(co[0]), .V(vf[0]));

  pipelined_signed_adder #(.N(16), .SEG(4), .SAT(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
    .A(A), .B(B), .Cin(Cin), .out_valid(ov[1]), .out_ready(ordy[1]),
    .Sum(sum[1]), .Cout(co[1]), .V(vf[1]));

  pipelined_signed_adder #(.N(16), .SEG(16), .SAT(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
    .A(A), .B(B), .Cin(Cin), .out_valid(ov[2]), .out_ready(ordy[2]),
    .Sum(sum[2]), .Cout(co[2]), .V(vf[2]));

  pipelined_signed_adder #(.N(16), .SEG(1), .SAT(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(rdy[3]),
    .A(A), .B(B), .Cin(Cin), .out_valid(ov[3]), .out_ready(ordy[3]),
    .Sum(sum[3]), .Cout(co[3]), .V(vf[3]));

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 2) ? 1 : (u == 3) ? 16 : 4;
  endfunction

  function automatic sb_t model(input int u, input logic [15:0] a,
                                input logic [15:0] b, input logic c);
    logic [16:0] f;
    sb_t e;
    f = {1'b0, a} + {1'b0, b} + 17'(c);
    e.u = u;
    e.c = f[16];
    e.v = (a[15] == b[15]) && (f[15] != a[15]);
    if (u == 1 && e.v) e.s = a[15] ? 16'h8000 : 16'h7fff;
    else               e.s = f[15:0];
    e.cyc = 0;
    e.lc  = 1'b0;
    return e;
  endfunction

  task automatic pop_check(input int u);
    sb_t e;
    check_eq("sb_nonempty", 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      n_out++;
      check_eq("unit", u, e.u);
      check_eq("sum", sum[u], e.s);
      check_eq("cout", co[u], e.c);
      check_eq("ovf", vf[u], e.v);
      if (e.lc) check_eq("latency", cyc - e.cyc, lat_of(u));
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      for (int u = 0; u < 4; u++)
        if (ov[u] && ordy[u]) pop_check(u);
      for (int u = 0; u < 4; u++)
        if (iv[u] && rdy[u]) begin
          e     = model(u, A, B, Cin);
          e.cyc = cyc;
          e.lc  = lat_chk;
          q.push_back(e);
        end
    end
  end

  // Entered and left at posedge+1; the token is taken at the next ready edge.
  task automatic send(input int u, input logic [15:0] a,
                      input logic [15:0] b, input logic c);
    int g = 0;
    A = a; B = b; Cin = c; iv[u] = 1'b1;
    @(negedge clk);
    while (!rdy[u] && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!rdy[u]) check_eq("send_wait", 32'(rdy[u]), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iv = '0; ordy = '1;
    A = '0; B = '0; Cin = 1'b0;
    #3;
    check_eq("rst_ov", ov, 0);
    check_eq("rst_sum0", sum[0], 0);
    check_eq("rst_sum3", sum[3], 0);
    check_eq("rst_cout", co, 0);
    check_eq("rst_v", vf, 0);
    check_eq("rst_rdy", rdy, 4'hf);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int u = 0; u < 2; u++) begin
      send(u, 16'h7fff, 16'h0001, 1'b0);
      send(u, 16'h8000, 16'hffff, 1'b0);
      send(u, 16'hffff, 16'h0000, 1'b1);
      send(u, 16'h1234, 16'h4321, 1'b0);
      send(u, 16'h8000, 16'h8000, 1'b0);
      send(u, 16'h7fff, 16'h7fff, 1'b1);
      iv[u] = 1'b0;
      drain();
    end

    send(2, 16'h1234, 16'h1111, 1'b0);
    send(2, 16'h7fff, 16'h0001, 1'b0);
    send(2, 16'hffff, 16'h0000, 1'b1);
    iv[2] = 1'b0;
    drain();

    lat_chk = 1'b0;
    n_out = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 16'(i), 16'h0100, 1'b0);
        iv[0] = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 ordy[0] = 1'b0;
        held = sum[0];
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("stall_rdy", 32'(rdy[0]), 0);
          check_eq("stall_ov", 32'(ov[0]), 1);
          check_eq("stall_sum", sum[0], held);
        end
        @(posedge clk);
        #1 ordy[0] = 1'b1;
      end
    join
    drain();
    check_eq("stream_cnt", n_out, 8);
    lat_chk = 1'b1;

    for (int i = 0; i < 4; i++) send(0, 16'h1000 + 16'(i), 16'h0001, 1'b0);
    iv[0] = 1'b0;
    check_eq("pre_rst_ov", 32'(ov[0]), 1);
    rst = 1'b1;
    q.delete();
    #1;
    check_eq("mid_rst_ov", 32'(ov[0]), 0);
    check_eq("mid_rst_sum", sum[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 16'h2222, 16'h1111, 1'b0);
    send(0, 16'h0fff, 16'h0001, 1'b0);
    iv[0] = 1'b0;
    drain();

    for (int i = 0; i < 30; i++)
      send(3, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    iv[3] = 1'b0;
    drain();

    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        iv[1] = 1'b0;
      end
      begin
        repeat (100) begin
          @(posedge clk);
          #1 ordy[1] = 1'($urandom_range(0, 1));
        end
        ordy[1] = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
